pe_feeder: RTL
==============

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, operand RAM address width; maximum vector length is 2^ADDR_W.
REQ-002 SHALL have parameter ACC_W, default 32, PE result width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset. Ports are listed below.
- aclk  in  1  clock; all state changes on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle job request; sampled in IDLE only.
- len  in  ADDR_W+1  element count of the dot product, 0..2^ADDR_W.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- ram_en  out  1  operand RAM read enable.
- ram_addr  out  ADDR_W  shared A/B read address; 1-cycle read latency.
- a_rdata  in  8  A operand read data.
- b_rdata  in  8  B operand read data.
- pe_ain  out  8  operand to PE port A.
- pe_din  out  8  operand to PE port B.
- pe_valid  out  1  PE issue strobe.
- pe_term  out  1  high with the first issue of a job; tells the PE to discard accumulator feedback.
- pe_dvalid  in  1  PE result-valid pulse.
- pe_dout  in  ACC_W  PE result.
- res_valid  out  1  final dot-product result available.
- res_data  out  ACC_W  final dot-product result.
- res_ready  in  1  downstream accepts the result.

Function
REQ-004 States: IDLE, PREFETCH, ISSUE, WAIT, RESULT.
REQ-005 IDLE + start + len>0: SHALL go to PREFETCH with the element counter set to 0. IDLE + start + len==0: SHALL go to RESULT with res_data=0.
REQ-006 PREFETCH: SHALL drive ram_en=1 and ram_addr=counter for one cycle, then capture a_rdata/b_rdata into operand registers in the next cycle. Total: 2 cycles, then go to ISSUE.
REQ-007 ISSUE (first element only): SHALL drive pe_valid=1 for exactly 1 cycle, with pe_term=1 and pe_ain/pe_din from the operand registers. It SHALL then increment the counter and go to WAIT.
REQ-008 WAIT with elements remaining: SHALL prefetch the next pair (REQ-006 timing) while waiting. When pe_dvalid=1, SHALL in that same cycle drive pe_valid=1 and pe_term=0, then increment the counter.
REQ-009 The same-cycle issue in REQ-008 is required because the PE feeds back pe_dout only while pe_dvalid is high. pe_valid SHALL be a combinational function of state and pe_dvalid; no register is allowed in that path.
REQ-010 WAIT with counter==len: on pe_dvalid=1, SHALL capture pe_dout into res_data and go to RESULT.
REQ-011 RESULT: SHALL hold res_valid=1 and res_data stable until res_ready=1. In the handshake cycle it SHALL return to IDLE; busy SHALL drop in the following cycle.
REQ-012 Outside ISSUE and the REQ-008 issue cycle, pe_valid=0 and pe_term=0.
REQ-013 pe_ain and pe_din SHALL hold their value between issues.
REQ-014 start SHALL be ignored while busy.
REQ-015 len and the counter SHALL be ACC-independent ADDR_W+1-bit quantities. len=2^ADDR_W SHALL read addresses 0..2^ADDR_W-1 with no address wrap inside a job.
REQ-016 pe_dvalid in IDLE, PREFETCH or RESULT SHALL be ignored, with no issue and no state change.
REQ-017 PE latency ≥3 cycles is a system requirement, so prefetch always completes before pe_dvalid. The bench SHALL flag a violation: pe_dvalid in WAIT before operands are captured.

Reset
REQ-018 When aresetn=0 the block SHALL go immediately to IDLE, including mid-job.
REQ-019 During reset all outputs SHALL be 0: busy, ram_en, ram_addr, pe_ain, pe_din, pe_valid, pe_term, res_valid, res_data.
REQ-020 Deassertion SHALL be synchronous to aclk, and the block SHALL accept start from the first active cycle.

Structure
REQ-021 A shared package SHALL hold the state enumeration and the ADDR_W and ACC_W defaults.
REQ-022 The block SHALL be a single module with no sub-modules. The bench SHALL instantiate it beside my_pe, or beside a behavioural MAC with latency L.

Verification
REQ-023 Job: len=4, A=[1,2,3,4], B=[5,6,7,8], L=4. Required: 4 pe_valid pulses, pe_term on the first only; res_data=70; busy high throughout.
REQ-024 Job: len=1, A=[0x7F], B=[0x02]. Required: a single issue with pe_term=1; res_data=254.
REQ-025 Job: len=0. Required: RESULT with res_data=0 within 2 cycles; no pe_valid; no ram_en.
REQ-026 Back-to-back jobs: [1,1]·[1,1], then [2]·[3]. Required: res 2 then 6. This proves pe_term clears the stale accumulator.
REQ-027 res_ready held low for 10 cycles. Required: res_valid/res_data stable; a start during that time is ignored.
REQ-028 aresetn pulsed low mid-WAIT of a len=8 job. Required: all outputs 0 immediately; a fresh len=2 job afterwards gives the correct result.

Source files
------------

// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE operand feeder: controller states, fetch phases and
// the default address / accumulator widths.
package pe_feeder_pkg;

   localparam int unsigned DefaultAddrW = 8;
   localparam int unsigned DefaultAccW  = 32;

   typedef enum logic [2:0] {
      StIdle,
      StPrefetch,
      StIssue,
      StWait,
      StResult
   } pf_state_e;

   // Operand fetch progress: request issued, data being captured, operands ready.
   typedef enum logic [1:0] {
      FetchReq,
      FetchCap,
      FetchDone
   } fetch_e;

endpackage

// File: rtl/pe_feeder.sv
// Streams operand pairs from a shared-address A/B RAM into a feedback MAC PE and
// returns the final dot product through a valid/ready result port.
module pe_feeder
   import pe_feeder_pkg::*;
#(
   parameter int unsigned ADDR_W = DefaultAddrW,
   parameter int unsigned ACC_W  = DefaultAccW
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        a_rdata,
   input  logic [7:0]        b_rdata,
   output logic [7:0]        pe_ain,
   output logic [7:0]        pe_din,
   output logic              pe_valid,
   output logic              pe_term,
   input  logic              pe_dvalid,
   input  logic [ACC_W-1:0]  pe_dout,
   output logic              res_valid,
   output logic [ACC_W-1:0]  res_data,
   input  logic              res_ready
);

   localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

   pf_state_e        state_q;
   fetch_e           fetch_q;
   logic [ADDR_W:0]  cnt_q;
   logic [ADDR_W:0]  len_q;
   logic [7:0]       op_a_q;
   logic [7:0]       op_b_q;
   logic [7:0]       hold_a_q;
   logic [7:0]       hold_b_q;
   logic [ACC_W-1:0] res_data_q;

   logic more;
   logic issue_wait;

   assign more       = (cnt_q != len_q);
   // The PE presents its feedback only while pe_dvalid is high, so the follow-on
   // issue must happen in that very cycle.
   assign issue_wait = (state_q == StWait) && more && pe_dvalid;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= StIdle;
         fetch_q    <= FetchReq;
         cnt_q      <= '0;
         len_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         hold_a_q   <= '0;
         hold_b_q   <= '0;
         res_data_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  len_q   <= len;
                  cnt_q   <= '0;
                  fetch_q <= FetchReq;
                  if (len == '0) begin
                     res_data_q <= '0;
                     state_q    <= StResult;
                  end else begin
                     state_q <= StPrefetch;
                  end
               end
            end
            StPrefetch: begin
               if (fetch_q == FetchReq) begin
                  fetch_q <= FetchCap;
               end else begin
                  op_a_q  <= a_rdata;
                  op_b_q  <= b_rdata;
                  fetch_q <= FetchDone;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               hold_a_q <= op_a_q;
               hold_b_q <= op_b_q;
               cnt_q    <= cnt_q + CntOne;
               fetch_q  <= FetchReq;
               state_q  <= StWait;
            end
            StWait: begin
               if (issue_wait) begin
                  hold_a_q <= op_a_q;
                  hold_b_q <= op_b_q;
                  cnt_q    <= cnt_q + CntOne;
                  fetch_q  <= FetchReq;
               end else if (more) begin
                  // Next pair is fetched while the PE is still computing.
                  if (fetch_q == FetchReq) begin
                     fetch_q <= FetchCap;
                  end else if (fetch_q == FetchCap) begin
                     op_a_q  <= a_rdata;
                     op_b_q  <= b_rdata;
                     fetch_q <= FetchDone;
                  end
               end else if (pe_dvalid) begin
                  res_data_q <= pe_dout;
                  state_q    <= StResult;
               end
            end
            StResult: begin
               if (res_ready) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      ram_en    = ((state_q == StPrefetch) || ((state_q == StWait) && more)) &&
                  (fetch_q == FetchReq);
      ram_addr  = ram_en ? cnt_q[ADDR_W-1:0] : '0;
      pe_term   = (state_q == StIssue);
      pe_valid  = pe_term || issue_wait;
      // Issue-cycle operands come straight from the fetch registers; otherwise the
      // last issued pair is held so the PE inputs stay stable between issues.
      pe_ain    = pe_valid ? op_a_q : hold_a_q;
      pe_din    = pe_valid ? op_b_q : hold_b_q;
      res_valid = (state_q == StResult);
      res_data  = res_data_q;
   end

endmodule
